// File: rtl/hevc_hfilter_stream_pkg.sv
// Shared HEVC luma interpolation definitions: frac encoding, 8-tap coefficient table, rounding.
// HFILTER_RAW_OUT_EN selects the 16-bit unrounded intermediate output width.
package hevc_interp_pkg;

   typedef enum logic [1:0] {
      FRAC_INT = 2'd0,
      FRAC_A   = 2'd1,
      FRAC_B   = 2'd2,
      FRAC_C   = 2'd3
   } frac_e;

   localparam int NUM_TAPS = 8;

   // Row index is the frac code; integer position is a pure 64x pass-through of tap 3.
   localparam int COEF [4][NUM_TAPS] = '{
      '{ 0, 0,   0, 64,  0,   0, 0,  0},
      '{-1, 4, -10, 58, 17,  -5, 1,  0},
      '{-1, 4, -11, 40, 40, -11, 4, -1},
      '{ 0, 1,  -5, 17, 58, -10, 4, -1}
   };

`ifdef HFILTER_RAW_OUT_EN
   localparam bit RAW_OUT = 1'b1;
`else
   localparam bit RAW_OUT = 1'b0;
`endif

   function automatic int out_width(input int pix_w);
      return RAW_OUT ? 16 : pix_w;
   endfunction

   function automatic int round_clip(input logic signed [31:0] sum, input int width);
      logic signed [31:0] r;
      int                 max_v;
      r     = (sum + 32'sd32) >>> 6;
      max_v = (1 << width) - 1;
      if (r < 0)
         return 0;
      else if (r > max_v)
         return max_v;
      else
         return r;
   endfunction

endpackage

// File: rtl/hevc_hfilter_stream_if.sv
// Row-stream handshake bundle for the horizontal sub-pixel filter (input rows, filtered output rows).
// Output row width follows hevc_interp_pkg::out_width, i.e. HFILTER_RAW_OUT_EN.
interface hevc_hfilter_stream_if #(
   parameter int NUM_PIXEL = 8,
   parameter int PIX_W     = 8,
   parameter int ROWS      = 15,
   parameter int OUT_W     = hevc_interp_pkg::out_width(PIX_W)
) ();
   localparam int IDX_W = $clog2(ROWS);

   logic                         in_valid;
   logic                         in_ready;
   logic [(NUM_PIXEL+7)*PIX_W-1:0] in_row;
   logic [1:0]                   frac;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_PIXEL*OUT_W-1:0]   out_row;
   logic                         out_last;
   logic [IDX_W-1:0]             out_row_idx;

   modport master (
      output in_valid, in_row, frac, out_ready,
      input  in_ready, out_valid, out_row, out_last, out_row_idx
   );

   modport slave (
      input  in_valid, in_row, frac, out_ready,
      output in_ready, out_valid, out_row, out_last, out_row_idx
   );
endinterface

// File: rtl/hevc_hfilter_stream_fir8.sv
// Combinational HEVC 8-tap luma MAC: eight unsigned pixels times the frac-selected coefficients.
module hevc_fir8 import hevc_interp_pkg::*; #(
   parameter int PIX_W = 8,
   parameter int ACC_W = PIX_W + 8
) (
   input  logic [NUM_TAPS*PIX_W-1:0] i_pix,
   input  logic [1:0]                i_frac,
   output logic signed [ACC_W-1:0]   o_sum
);
   int w_acc;

   always_comb begin
      w_acc = 0;
      for (int unsigned t = 0; t < NUM_TAPS; t++)
         w_acc = w_acc + COEF[i_frac][t] * int'(i_pix[t*PIX_W +: PIX_W]);
   end

   assign o_sum = ACC_W'(w_acc);
endmodule

// File: rtl/hevc_hfilter_stream.sv
// Streaming HEVC horizontal luma filter: one row per beat, two-stage pipe, full back-pressure.
// HFILTER_RAW_OUT_EN: emit the 16-bit unrounded sum instead of the rounded, clipped pixel.
module hevc_hfilter_stream import hevc_interp_pkg::*; #(
   parameter int NUM_PIXEL = 8,
   parameter int PIX_W     = 8,
   parameter int ROWS      = 15,
   parameter int ACC_W     = PIX_W + 8,
   parameter int OUT_W     = out_width(PIX_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   hevc_hfilter_stream_if.slave  bus,
   output logic                  busy
);
   localparam int               IDX_W    = $clog2(ROWS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

   logic                       w_advance;
   logic                       w_accept;
   logic [1:0]                 w_frac;
   logic signed [ACC_W-1:0]    w_sum [NUM_PIXEL];
   logic [NUM_PIXEL*OUT_W-1:0] w_s2_row;

   logic [IDX_W-1:0]           r_row_cnt;
   frac_e                      r_frac;

   logic                       r_s1_valid;
   logic                       r_s1_last;
   logic [IDX_W-1:0]           r_s1_idx;
   logic signed [ACC_W-1:0]    r_s1_sum [NUM_PIXEL];

   logic                       r_s2_valid;
   logic                       r_s2_last;
   logic [IDX_W-1:0]           r_s2_idx;
   logic [NUM_PIXEL*OUT_W-1:0] r_s2_row;

   assign w_advance = !r_s2_valid || bus.out_ready;
   assign w_accept  = bus.in_valid && w_advance;

   // The first row of a block filters with the live frac; later rows use the latched copy.
   assign w_frac = (r_row_cnt == '0) ? bus.frac : r_frac;

   for (genvar g = 0; g < NUM_PIXEL; g++) begin : g_fir
      hevc_fir8 #(
         .PIX_W (PIX_W),
         .ACC_W (ACC_W)
      ) u_fir (
         .i_pix  (bus.in_row[g*PIX_W +: NUM_TAPS*PIX_W]),
         .i_frac (w_frac),
         .o_sum  (w_sum[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_row_cnt <= '0;
         r_frac    <= FRAC_INT;
      end else if (w_accept) begin
         if (r_row_cnt == '0)
            r_frac <= frac_e'(bus.frac);
         r_row_cnt <= (r_row_cnt == LAST_IDX) ? '0 : r_row_cnt + IDX_W'(1);
      end
   end

   always_comb begin
      w_s2_row = '0;
      for (int unsigned i = 0; i < NUM_PIXEL; i++) begin
`ifdef HFILTER_RAW_OUT_EN
         w_s2_row[i*OUT_W +: OUT_W] = OUT_W'(r_s1_sum[i]);
`else
         w_s2_row[i*OUT_W +: OUT_W] = OUT_W'(round_clip(32'(r_s1_sum[i]), PIX_W));
`endif
      end
   end

   // Both stages move together; a stalled S2 freezes S1 and the input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_idx   <= '0;
         r_s1_sum   <= '{default: '0};
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_idx   <= '0;
         r_s2_row   <= '0;
      end else if (w_advance) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_sum  <= w_sum;
            r_s1_idx  <= r_row_cnt;
            r_s1_last <= (r_row_cnt == LAST_IDX);
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_row  <= w_s2_row;
            r_s2_idx  <= r_s1_idx;
            r_s2_last <= r_s1_last;
         end
      end
   end

   assign bus.in_ready    = w_advance;
   assign bus.out_valid   = r_s2_valid;
   assign bus.out_row     = r_s2_row;
   assign bus.out_last    = r_s2_last;
   assign bus.out_row_idx = r_s2_idx;
   assign busy            = (r_row_cnt != '0) || r_s1_valid || r_s2_valid;
endmodule
